// File: rtl/req_drain_encoder.sv
// rtl/req_drain_encoder.sv - drains a multi-hot request mask as descending binary indices
module req_drain_encoder #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW-1:0]          out_index,
    output logic                   out_last,
    output logic                   zero_drop,
    output logic [$clog2(W+1)-1:0] served_cnt
);

    localparam int CW = $clog2(W+1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]    state;
    logic [W-1:0]  pending;
    logic [IW-1:0] msb_idx;

    // Ascending scan so the last hit wins: that is the most-significant set bit.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (pending[i]) begin
                msb_idx = IW'(i);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DRAIN);
    assign out_index = msb_idx;
    assign out_last  = (pending != '0) && ((pending & (pending - W'(1))) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            served_cnt <= '0;
            zero_drop  <= 1'b0;
        end else begin
            zero_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_mask != '0) begin
                            pending    <= in_mask;
                            served_cnt <= '0;
                            state      <= DRAIN;
                        end else begin
                            zero_drop <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        served_cnt <= served_cnt + CW'(1);
                        if (out_last) begin
                            pending <= '0;
                            state   <= IDLE;
                        end else begin
                            pending <= pending & ~(W'(1) << msb_idx);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_drain_encoder.sv
// tb/tb_req_drain_encoder.sv - randomized and directed check of req_drain_encoder against a queue model
module tb_req_drain_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic       out_last;
    logic       zero_drop;
    logic [3:0] served_cnt;

    int errors = 0;
    int checks = 0;

    // Model: the indices still owed for the current mask, highest first.
    int q[$];
    int served = 0;
    bit zd = 1'b0;

    req_drain_encoder #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .zero_drop  (zero_drop),
        .served_cnt (served_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        if (obs != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (q.size() != 0);
        check("in_ready",   int'(in_ready),   int'(!busy));
        check("out_valid",  int'(out_valid),  int'(busy));
        check("out_index",  int'(out_index),  busy ? q[0] : 0);
        check("out_last",   int'(out_last),   int'(busy && q.size() == 1));
        check("served_cnt", int'(served_cnt), served);
        check("zero_drop",  int'(zero_drop),  int'(zd));
    endtask

    // Called at a falling edge: drive inputs, advance the model, clock, then compare.
    task automatic step(input logic r, input logic iv, input logic [7:0] m, input logic ordy);
        rst_n     = r;
        in_valid  = iv;
        in_mask   = m;
        out_ready = ordy;
        if (!r) begin
            q.delete();
            served = 0;
            zd     = 1'b0;
        end else if (q.size() == 0) begin
            zd = iv && (m == 8'h00);
            if (iv && m != 8'h00) begin
                for (int i = 7; i >= 0; i--) begin
                    if (m[i]) q.push_back(i);
                end
                served = 0;
            end
        end else begin
            zd = 1'b0;
            if (ordy) begin
                void'(q.pop_front());
                served++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 8'hFF;
        out_ready = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Mixed mask drained at full rate
        step(1'b1, 1'b1, 8'hA6, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        check("a6_served_end", int'(served_cnt), 4);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Single bit 0
        step(1'b1, 1'b1, 8'h01, 1'b0);
        check("b0_last", int'(out_last), 1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("b0_served", int'(served_cnt), 1);

        // All-zero mask
        step(1'b1, 1'b1, 8'h00, 1'b1);
        check("zero_pulse", int'(zero_drop), 1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Full mask with a 3-cycle stall
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'h0F, 1'b0);
        check("ff_stall_idx", int'(out_index), 7);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        check("ff_served", int'(served_cnt), 8);

        // Reset mid-drain discards the rest of the mask
        step(1'b1, 1'b1, 8'hC0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        check("rst_valid", int'(out_valid), 0);
        step(1'b1, 1'b1, 8'h08, 1'b0);
        check("after_rst_idx", int'(out_index), 3);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // in_valid held with a churning mask during a drain
        step(1'b1, 1'b1, 8'h11, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 8'($urandom), 1'b1);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            logic       r;
            logic [7:0] m;
            r = ($urandom_range(0, 59) != 0);
            case ($urandom_range(0, 3))
                0:       m = 8'h00;
                1:       m = 8'(1 << $urandom_range(0, 7));
                default: m = 8'($urandom);
            endcase
            step(r, 1'($urandom_range(0, 1)), m, ($urandom_range(0, 9) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_drain_encoder.md
REQ_DRAIN_ENCODER -- requirements
Module: req_drain_encoder

Interface
REQ-001 SHALL have parameter: W, 8, width of the request mask; legal range 2..16.
REQ-002 SHALL have parameter: IW, $clog2(W), width of the emitted index.
REQ-003 SHALL have one clock and a synchronous active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port: in_valid  input  1  request mask offered.
REQ-006 SHALL have port: in_ready  output  1  block can accept a mask.
REQ-007 SHALL have port: in_mask  input  W  multi-hot request mask; bit W-1 is highest priority.
REQ-008 SHALL have port: out_valid  output  1  out_index is valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts out_index.
REQ-010 SHALL have port: out_index  output  IW  binary index of the highest-priority pending bit.
REQ-011 SHALL have port: out_last  output  1  current index is the final pending bit of the mask.
REQ-012 SHALL have port: zero_drop  output  1  one-cycle pulse when an all-zero mask is accepted.
REQ-013 SHALL have port: served_cnt  output  $clog2(W+1)  indices accepted from the current mask.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, DRAIN.
REQ-015 In IDLE: in_ready=1, out_valid=0; in DRAIN: in_ready=0, out_valid=1.
REQ-016 Input handshake: transfer occurs on a rising clk with in_valid=1 and in_ready=1; no other cycle samples in_mask.
REQ-017 On an IDLE transfer with in_mask!=0: pending<=in_mask, served_cnt<=0, state<=DRAIN.
REQ-018 On an IDLE transfer with in_mask==0: state stays IDLE, pending unchanged, zero_drop=1 for the following cycle only.
REQ-019 Latency: mask accepted at edge N -> out_valid=1 with the first index in the cycle after edge N.
REQ-020 out_index SHALL equal the position of the most-significant set bit of pending (combinational from registered pending).
REQ-021 out_last SHALL be 1 exactly when pending has one bit set.
REQ-022 Output handshake: transfer on a rising clk with out_valid=1 and out_ready=1; pending clears the bit at out_index; served_cnt increments by 1.
REQ-023 If the transfer has out_last=1: state<=IDLE, pending<=0; served_cnt holds its final value until the next mask load.
REQ-024 While out_valid=1 and out_ready=0: out_index, out_last, served_cnt and pending SHALL be held stable.
REQ-025 Indices SHALL be emitted in strictly descending order; each set bit of the mask is emitted exactly once.
REQ-026 A new mask SHALL NOT be accepted in the cycle of the last output transfer; at least one IDLE cycle separates masks.
REQ-027 in_mask changes while in DRAIN SHALL have no effect.
REQ-028 out_ready toggling while in IDLE SHALL have no effect.

Reset
REQ-029 With rst_n=0 at a rising clk: state<=IDLE, pending<=0, served_cnt<=0, zero_drop<=0; in_ready=1, out_valid=0, out_index=0, out_last=0 from the following cycle.
REQ-030 Reset asserted mid-DRAIN SHALL discard all pending bits; no further index is emitted for that mask.
REQ-031 in_valid SHALL be ignored in any cycle in which rst_n=0.

Verification
REQ-032 Mask 8'b1010_0110, out_ready=1 -> indices 7,5,2,1 on 4 consecutive cycles; out_last only with 1; served_cnt ends at 4; in_ready back to 1 next cycle.
REQ-033 Mask 8'b0000_0001 -> single index 0 with out_last=1; served_cnt=1; state returns to IDLE.
REQ-034 Mask 8'h00 -> zero_drop=1 for one cycle; out_valid stays 0; in_ready stays 1.
REQ-035 Mask 8'hFF, out_ready held 0 for 3 cycles then 1 -> out_index=7 stable while stalled, then 7..0 emitted; total 8 transfers.
REQ-036 Mask 8'b1100_0000, rst_n=0 after first transfer (index 7) -> no index 6 emitted; outputs at reset values; next mask 8'b0000_1000 yields index 3.
REQ-037 in_valid held 1 with changing in_mask throughout DRAIN of 8'b0001_0001 -> only indices 4,0 emitted; next mask accepted no earlier than one cycle after the last transfer.
